// File: rtl/jt03_wr_seq.sv
// jt03_wr_seq: FIFO-buffered YM2203 address/data write sequencer with busy polling; JT03_WR_SEQ_ADDR_CACHE_EN skips repeated address writes
module jt03_wr_seq #(
  parameter int FIFO_AW   = 3,
  parameter int WR_PULSE  = 2,
  parameter int BUSY_SKIP = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               cmd_valid,
  input  logic [7:0]         cmd_reg,
  input  logic [7:0]         cmd_val,
  output logic               cmd_ready,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               tout_err,
  input  logic               clr_err,
  input  logic [7:0]         chip_dout,
  output logic [7:0]         chip_din,
  output logic               chip_addr,
  output logic               chip_cs_n,
  output logic               chip_wr_n
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW = FIFO_AW + 1;
  localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE - 1);
  localparam logic [7:0] SKIP = 8'(BUSY_SKIP);
  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ADR_WR, ADR_GAP, DAT_WR, BWAIT} state_t;
  state_t state;
  logic [15:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] level_n;
  logic [7:0] head_reg, head_val, val_l;
  logic [3:0] pcnt, pcnt_inc;
  logic [7:0] wcnt, wcnt_inc;
  logic push, pop, skip_adr, bw_done, bw_tout, tout_set;
  logic unused_dout;
  assign unused_dout = ^chip_dout[6:0];
  assign {head_reg, head_val} = mem[rd_ptr];
  assign push = cmd_valid & cmd_ready;
  assign pop = cen & (state == IDLE) & (level != '0);
  assign level_n = level + LW'(push) - LW'(pop);
  assign busy = (level != '0) | (state != IDLE);
  assign pcnt_inc = (pcnt == 4'hf) ? pcnt : pcnt + 4'd1;
  assign wcnt_inc = (wcnt == 8'hff) ? wcnt : wcnt + 8'd1;
  assign bw_done = (wcnt >= SKIP) & ~chip_dout[7];
  assign bw_tout = wcnt >= TOUT_LAST;
  assign tout_set = cen & (state == BWAIT) & bw_tout & ~bw_done;
`ifdef JT03_WR_SEQ_ADDR_CACHE_EN
  logic [7:0] cache_reg;
  logic cache_vld;
  assign skip_adr = cache_vld & (cache_reg == head_reg);
  always_ff @(posedge clk)
    if (rst) cache_vld <= 1'b0;
    else if (cen && state == ADR_WR && pcnt >= PULSE_LAST) begin
      cache_vld <= 1'b1;
      cache_reg <= chip_din;
    end
`else
  assign skip_adr = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_reg, cmd_val};
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cmd_ready <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      level <= level_n;
      cmd_ready <= level_n != LW'(DEPTH);
    end
  always_ff @(posedge clk)
    if (rst) tout_err <= 1'b0;
    else tout_err <= tout_set | (tout_err & ~clr_err);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      chip_din <= '0;
      chip_addr <= 1'b0;
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
      pcnt <= '0;
      wcnt <= '0;
      val_l <= '0;
    end else if (cen) begin
      case (state)
        IDLE: if (level != '0) begin
          val_l <= head_val;
          pcnt <= '0;
          chip_cs_n <= 1'b0;
          chip_wr_n <= 1'b0;
          chip_addr <= skip_adr;
          chip_din <= skip_adr ? head_val : head_reg;
          state <= skip_adr ? DAT_WR : ADR_WR;
        end
        ADR_WR: if (pcnt >= PULSE_LAST) begin
          state <= ADR_GAP;
          chip_cs_n <= 1'b1;
          chip_wr_n <= 1'b1;
        end else pcnt <= pcnt_inc;
        ADR_GAP: begin
          state <= DAT_WR;
          pcnt <= '0;
          chip_addr <= 1'b1;
          chip_din <= val_l;
          chip_cs_n <= 1'b0;
          chip_wr_n <= 1'b0;
        end
        DAT_WR: if (pcnt >= PULSE_LAST) begin
          state <= BWAIT;
          wcnt <= '0;
          chip_addr <= 1'b0;
          chip_wr_n <= 1'b1;
        end else pcnt <= pcnt_inc;
        BWAIT: if (bw_done || bw_tout) begin
          state <= IDLE;
          chip_cs_n <= 1'b1;
        end else wcnt <= wcnt_inc;
        default: state <= IDLE;
      endcase
    end
endmodule
